data_wbuf: RTL and testbench

- Posted write buffer between the core's data SRAM-like port and the AXI bridge's data SRAM-like port, on the data side of the CPU top level.
- Stores are acknowledged to the core one cycle after acceptance, then drained in order to the bridge in the background.
- Loads are serialised behind all buffered and outstanding stores, so memory ordering is preserved without address compare.

---
 rtl/data_wbuf.sv | 145 ++++++++++++++
 tb/tb_data_wbuf.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_wbuf.sv
// rtl/data_wbuf.sv - posted data-side write buffer between core and AXI bridge
// Stores are acked the cycle after acceptance and drained in order; loads wait for all stores to complete.
module data_wbuf #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [1:0]  cpu_size,
    input  logic [3:0]  cpu_wstrb,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_addr_ok,
    output logic        cpu_data_ok,
    output logic [31:0] cpu_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        wbuf_empty
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] WMAX     = '1;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_WAIT = 1'b1
    } rd_state_e;

    rd_state_e        state_q, state_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic [PTR_W:0]   wcnt_q, wcnt_d;
    logic             st_ack_q, st_ack_d;

    logic [31:0] addr_mem  [DEPTH];
    logic [1:0]  size_mem  [DEPTH];
    logic [3:0]  wstrb_mem [DEPTH];
    logic [31:0] wdata_mem [DEPTH];

    logic idle, full, push, drain, pop, ld_req, ld_hs, wresp, rd_done;

    // reset gating keeps every handshake output quiet while reset is held
    always_comb begin
        idle    = (state_q == RD_IDLE) & ~reset;
        full    = (cnt_q == FULL_CNT);
        push    = idle & cpu_req & cpu_wr & ~full;
        drain   = idle & (cnt_q != '0) & (wcnt_q < WMAX);
        pop     = drain & mem_addr_ok;
        ld_req  = idle & cpu_req & ~cpu_wr & (cnt_q == '0) & (wcnt_q == '0);
        ld_hs   = ld_req & mem_addr_ok;
        wresp   = idle & mem_data_ok;
        rd_done = (state_q == RD_WAIT) & ~reset & mem_data_ok;
    end

    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        tail_d   = tail_q;
        cnt_d    = cnt_q;
        wcnt_d   = wcnt_q;
        st_ack_d = push;
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (pop && !wresp) begin
            wcnt_d = wcnt_q + 1'b1;
        end else if (!pop && wresp) begin
            wcnt_d = wcnt_q - 1'b1;
        end
        if (ld_hs) begin
            state_d = RD_WAIT;
        end else if (rd_done) begin
            state_d = RD_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RD_IDLE;
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
            wcnt_q   <= '0;
            st_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            cnt_q    <= cnt_d;
            wcnt_q   <= wcnt_d;
            st_ack_q <= st_ack_d;
        end
    end

    // entry payload needs no reset; validity is tracked by cnt_q alone
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_q]  <= cpu_addr;
            size_mem[tail_q]  <= cpu_size;
            wstrb_mem[tail_q] <= cpu_wstrb;
            wdata_mem[tail_q] <= cpu_wdata;
        end
    end

    always_comb begin
        cpu_addr_ok = push | ld_hs;
        cpu_data_ok = st_ack_q | rd_done;
        cpu_rdata   = rd_done ? mem_rdata : 32'h0;
        mem_req     = drain | ld_req;
        mem_wr      = drain;
        mem_size    = 2'b00;
        mem_wstrb   = 4'h0;
        mem_addr    = 32'h0;
        mem_wdata   = 32'h0;
        if (drain) begin
            mem_size  = size_mem[head_q];
            mem_wstrb = wstrb_mem[head_q];
            mem_addr  = addr_mem[head_q];
            mem_wdata = wdata_mem[head_q];
        end else if (ld_req) begin
            mem_size = cpu_size;
            mem_addr = cpu_addr;
        end
        wbuf_empty = (cnt_q == '0) & (wcnt_q == '0);
    end

endmodule

// File: tb/tb_data_wbuf.sv
// tb/tb_data_wbuf.sv - self-checking bench for data_wbuf
// Queue-based model checked every cycle plus directed literal expectations.
module tb_data_wbuf;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_wr;
    logic [1:0]  cpu_size;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_addr_ok, cpu_data_ok;
    logic [31:0] cpu_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        wbuf_empty;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;

    data_wbuf #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_wstrb(cpu_wstrb),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .wbuf_empty(wbuf_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } ent_t;

    // Model: queued stores, writes in flight at the bridge, pending load, pending store ack
    initial begin
        ent_t q[$];
        int   outst;
        bit   ld_busy, ack;
        bit   act, push, drain, ld;
        logic        e_aok, e_dok, e_req, e_wr, e_empty;
        logic [1:0]  e_size;
        logic [3:0]  e_wstrb;
        logic [31:0] e_rdata, e_addr, e_wdata;
        outst = 0; ld_busy = 0; ack = 0;
        forever begin
            @(negedge clk);
            if (started) begin
                if (reset) begin
                    q.delete(); outst = 0; ld_busy = 0; ack = 0;
                end
                act   = !reset;
                push  = act && !ld_busy && cpu_req && cpu_wr && (q.size() < 4);
                drain = act && !ld_busy && (q.size() > 0) && (outst < 7);
                ld    = act && !ld_busy && cpu_req && !cpu_wr && (q.size() == 0) && (outst == 0);
                e_aok   = push || (ld && mem_addr_ok);
                e_dok   = ack || (act && ld_busy && mem_data_ok);
                e_rdata = (act && ld_busy && mem_data_ok) ? mem_rdata : 32'h0;
                e_req   = drain || ld;
                e_wr    = drain;
                e_size = 2'b00; e_wstrb = 4'h0; e_addr = 32'h0; e_wdata = 32'h0;
                if (drain) begin
                    e_size = q[0].size; e_wstrb = q[0].wstrb; e_addr = q[0].addr; e_wdata = q[0].wdata;
                end else if (ld) begin
                    e_size = cpu_size; e_addr = cpu_addr;
                end
                e_empty = (q.size() == 0) && (outst == 0);
                chk("m_cpu_addr_ok", cpu_addr_ok, e_aok);
                chk("m_cpu_data_ok", cpu_data_ok, e_dok);
                chk("m_cpu_rdata",   cpu_rdata,   e_rdata);
                chk("m_mem_req",     mem_req,     e_req);
                chk("m_mem_wr",      mem_wr,      e_wr);
                chk("m_mem_size",    mem_size,    e_size);
                chk("m_mem_wstrb",   mem_wstrb,   e_wstrb);
                chk("m_mem_addr",    mem_addr,    e_addr);
                chk("m_mem_wdata",   mem_wdata,   e_wdata);
                chk("m_wbuf_empty",  wbuf_empty,  e_empty);
                if (act) begin
                    if (drain && mem_addr_ok) begin
                        void'(q.pop_front());
                        outst++;
                    end
                    if (!ld_busy && mem_data_ok) outst--;
                    if (push) q.push_back('{cpu_addr, cpu_size, cpu_wstrb, cpu_wdata});
                    ack = push;
                    if (ld_busy && mem_data_ok) ld_busy = 0;
                    else if (ld && mem_addr_ok) ld_busy = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic wr, input logic [1:0] sz, input logic [3:0] st,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic aok, input logic dok, input logic [31:0] rd);
        cpu_req = req; cpu_wr = wr; cpu_size = sz; cpu_wstrb = st; cpu_addr = a; cpu_wdata = d;
        mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = rd;
        #2;
    endtask

    task automatic idle_cyc(input logic aok, input logic dok, input logic [31:0] rd);
        tick();
        drive(0, 0, 2'd0, 4'h0, 32'h0, 32'h0, aok, dok, rd);
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 0; cpu_wr = 0; cpu_size = 0; cpu_wstrb = 0; cpu_addr = 0; cpu_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
        @(posedge clk);
        started = 1'b1;
        #3;
        chk("rst_empty", wbuf_empty, 1'b1);
        chk("rst_req", mem_req, 1'b0);
        tick(); reset = 1'b0;

        // 1: single word store with bridge stalling 3 cycles
        tick(); drive(1, 1, 2'd2, 4'hf, 32'h1c000100, 32'hdeadbeef, 0, 0, 0);
        chk("t1_aok", cpu_addr_ok, 1'b1);
        chk("t1_noreq", mem_req, 1'b0);
        idle_cyc(0, 0, 0);
        chk("t1_dok", cpu_data_ok, 1'b1);
        chk("t1_rdata0", cpu_rdata, 32'h0);
        chk("t1_addr", mem_addr, 32'h1c000100);
        idle_cyc(0, 0, 0);
        chk("t1_hold2", mem_req, 1'b1);
        idle_cyc(0, 0, 0);
        chk("t1_hold3", mem_wdata, 32'hdeadbeef);
        idle_cyc(1, 0, 0);
        chk("t1_pop_req", mem_req, 1'b1);
        idle_cyc(0, 0, 0);
        chk("t1_popped", mem_req, 1'b0);
        chk("t1_notempty", wbuf_empty, 1'b0);
        idle_cyc(0, 1, 0);
        chk("t1_resp_cyc", wbuf_empty, 1'b0);
        idle_cyc(0, 0, 0);
        chk("t1_empty", wbuf_empty, 1'b1);

        // 2: fill to DEPTH, fifth store stalls until first pop
        for (int i = 0; i < 5; i++) begin
            tick(); drive(1, 1, 2'd2, 4'hf, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 0, 0, 0);
            chk("t2_aok", cpu_addr_ok, (i < 4) ? 1'b1 : 1'b0);
        end
        tick(); drive(1, 1, 2'd2, 4'hf, 32'h110, 32'hA4, 1, 0, 0);
        chk("t2_full_pop_aok", cpu_addr_ok, 1'b0);
        chk("t2_head0", mem_addr, 32'h100);
        tick(); drive(1, 1, 2'd2, 4'hf, 32'h110, 32'hA4, 0, 0, 0);
        chk("t2_fifth_aok", cpu_addr_ok, 1'b1);
        for (int i = 1; i < 5; i++) begin
            idle_cyc(1, 0, 0);
            chk("t2_order", mem_addr, 32'h100 + 32'(4 * i));
        end
        for (int i = 0; i < 5; i++) idle_cyc(0, 1, 0);
        idle_cyc(0, 0, 0);
        chk("t2_empty", wbuf_empty, 1'b1);

        // 3: load behind a store to the same address
        tick(); drive(1, 1, 2'd2, 4'hf, 32'h200, 32'h12345678, 0, 0, 0);
        chk("t3_st_aok", cpu_addr_ok, 1'b1);
        tick(); drive(1, 0, 2'd2, 4'h0, 32'h200, 32'h0, 1, 0, 0);
        chk("t3_ld_blk1", cpu_addr_ok, 1'b0);
        chk("t3_drain_wr", mem_wr, 1'b1);
        tick(); drive(1, 0, 2'd2, 4'h0, 32'h200, 32'h0, 1, 0, 0);
        chk("t3_ld_blk2", cpu_addr_ok, 1'b0);
        tick(); drive(1, 0, 2'd2, 4'h0, 32'h200, 32'h0, 1, 1, 0);
        chk("t3_ld_blk3", cpu_addr_ok, 1'b0);
        tick(); drive(1, 0, 2'd2, 4'h0, 32'h200, 32'h0, 1, 0, 0);
        chk("t3_ld_aok", cpu_addr_ok, 1'b1);
        chk("t3_ld_wr", mem_wr, 1'b0);
        chk("t3_ld_size", mem_size, 2'd2);
        idle_cyc(0, 1, 32'h12345678);
        chk("t3_ld_dok", cpu_data_ok, 1'b1);
        chk("t3_ld_rdata", cpu_rdata, 32'h12345678);
        idle_cyc(0, 0, 0);
        chk("t3_quiet", cpu_data_ok, 1'b0);

        // 4: store held off while a load is outstanding
        tick(); drive(1, 0, 2'd2, 4'h0, 32'h400, 32'h0, 1, 0, 0);
        chk("t4_ld_aok", cpu_addr_ok, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(); drive(1, 1, 2'd2, 4'hf, 32'h404, 32'h55, 0, 0, 0);
            chk("t4_st_blk", cpu_addr_ok, 1'b0);
        end
        tick(); drive(1, 1, 2'd2, 4'hf, 32'h404, 32'h55, 0, 1, 32'hcafef00d);
        chk("t4_ld_dok", cpu_data_ok, 1'b1);
        chk("t4_ld_rdata", cpu_rdata, 32'hcafef00d);
        chk("t4_st_blk_last", cpu_addr_ok, 1'b0);
        tick(); drive(1, 1, 2'd2, 4'hf, 32'h404, 32'h55, 0, 0, 0);
        chk("t4_st_aok", cpu_addr_ok, 1'b1);
        idle_cyc(1, 0, 0);
        chk("t4_st_ack", cpu_data_ok, 1'b1);
        chk("t4_drain_addr", mem_addr, 32'h404);
        idle_cyc(0, 1, 0);
        idle_cyc(0, 0, 0);
        chk("t4_empty", wbuf_empty, 1'b1);

        // 5: byte store fields pass through unchanged
        tick(); drive(1, 1, 2'd0, 4'b0100, 32'h302, 32'h00ab0000, 0, 0, 0);
        chk("t5_aok", cpu_addr_ok, 1'b1);
        idle_cyc(1, 0, 0);
        chk("t5_size", mem_size, 2'd0);
        chk("t5_addr", mem_addr, 32'h302);
        chk("t5_wstrb", mem_wstrb, 4'b0100);
        chk("t5_wdata", mem_wdata, 32'h00ab0000);
        idle_cyc(0, 1, 0);
        idle_cyc(0, 0, 0);
        chk("t5_empty", wbuf_empty, 1'b1);

        // 6: reset with two entries buffered and one write outstanding
        tick(); drive(1, 1, 2'd2, 4'hf, 32'h500, 32'h1, 0, 0, 0);
        tick(); drive(1, 1, 2'd2, 4'hf, 32'h504, 32'h2, 1, 0, 0);
        tick(); drive(1, 1, 2'd2, 4'hf, 32'h508, 32'h3, 0, 0, 0);
        chk("t6_pre_empty", wbuf_empty, 1'b0);
        tick(); reset = 1'b1;
        drive(1, 0, 2'd2, 4'h0, 32'h700, 32'h0, 1, 0, 0);
        chk("t6_rst_aok", cpu_addr_ok, 1'b0);
        chk("t6_rst_dok", cpu_data_ok, 1'b0);
        chk("t6_rst_req", mem_req, 1'b0);
        chk("t6_rst_empty", wbuf_empty, 1'b1);
        tick(); reset = 1'b0;
        drive(0, 0, 2'd0, 4'h0, 32'h0, 32'h0, 0, 0, 0);
        chk("t6_post_req", mem_req, 1'b0);
        idle_cyc(0, 0, 0);
        chk("t6_post_req2", mem_req, 1'b0);
        tick(); drive(1, 1, 2'd2, 4'hf, 32'h600, 32'h6, 0, 0, 0);
        chk("t6_new_aok", cpu_addr_ok, 1'b1);
        idle_cyc(1, 0, 0);
        chk("t6_new_addr", mem_addr, 32'h600);
        idle_cyc(0, 1, 0);
        idle_cyc(0, 0, 0);
        chk("t6_empty", wbuf_empty, 1'b1);

        idle_cyc(0, 0, 0);
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
